reg_cmd_ctrl: RTL and testbench

Byte-stream command controller that masters the register file. It consumes command frames from the UART receive path, issues single-cycle write or read strobes to the register file, and returns read data as a byte to the UART transmit path. It sits between the RX deserializer and the register-file port, in the reference clock domain.

---
 rtl/reg_cmd_ctrl_pkg.sv | 29 ++
 rtl/reg_cmd_ctrl_if.sv | 35 +++
 rtl/reg_cmd_ctrl.sv | 123 ++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_cmd_ctrl_pkg : opcodes, widths and FSM states shared by the command path
// Revision 1.0
// ---------------------------------------------------------------------------
package reg_cmd_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ADD_W  = 4;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  // Cycles allowed from the RdEn cycle to the read-data qualifier
  localparam int RD_TIMEOUT = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_STB  = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_STB  = 3'd5,
    ST_RD_WAIT = 3'd6,
    ST_TX_SEND = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_cmd_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_cmd_ctrl_if : RX byte stream, register-file port and TX byte stream
// Revision 1.0
// ---------------------------------------------------------------------------
interface reg_cmd_ctrl_if #(
  parameter int DATA = reg_cmd_ctrl_pkg::DATA_W,
  parameter int ADD  = reg_cmd_ctrl_pkg::ADD_W
);

  logic [DATA-1:0] RX_P_DATA;
  logic            RX_D_VLD;
  logic [DATA-1:0] RdData;
  logic            RdData_Valid;
  logic            TX_BUSY;
  logic            WrEn;
  logic            RdEn;
  logic [ADD-1:0]  Address;
  logic [DATA-1:0] WrData;
  logic [DATA-1:0] TX_P_DATA;
  logic            TX_D_VLD;
  logic            CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

endinterface
`default_nettype wire

// File: rtl/reg_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_cmd_ctrl : decodes AA/BB command frames into register-file strobes and
//                returns read data as a TX byte. Requires ADD < DATA.
// Revision 1.0
// ---------------------------------------------------------------------------
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int DATA = DATA_W,
  parameter int ADD  = ADD_W
) (
  input  logic           CLK,
  input  logic           RST,
  reg_cmd_ctrl_if.master bus
);

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_cnt;
  logic            r_wren;
  logic            r_rden;
  logic            r_txvld;
  logic            r_err;
  logic [ADD-1:0]  r_addr;
  logic [DATA-1:0] r_wrdata;
  logic [DATA-1:0] r_txdata;

  logic w_wren;
  logic w_rden;
  logic w_txvld;
  logic w_err;
  logic w_ld_addr;
  logic w_ld_wrdata;
  logic w_ld_txdata;
  logic w_hi_nz;
  logic w_is_wr;
  logic w_is_rd;
  logic w_timeout;

  assign w_hi_nz   = |bus.RX_P_DATA[DATA-1:ADD];
  assign w_is_wr   = (bus.RX_P_DATA == DATA'(CMD_WR));
  assign w_is_rd   = (bus.RX_P_DATA == DATA'(CMD_RD));
  // Last RD_WAIT cycle whose qualifier can still be accepted
  assign w_timeout = (r_state == ST_RD_WAIT) && !bus.RdData_Valid &&
                     (r_cnt == 3'(RD_TIMEOUT - 2));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.RX_D_VLD && w_is_wr)      w_next = ST_WR_ADDR;
        else if (bus.RX_D_VLD && w_is_rd) w_next = ST_RD_ADDR;
      end
      ST_WR_ADDR: if (bus.RX_D_VLD) w_next = w_hi_nz ? ST_IDLE : ST_WR_DATA;
      ST_RD_ADDR: if (bus.RX_D_VLD) w_next = w_hi_nz ? ST_IDLE : ST_RD_STB;
      ST_WR_DATA: if (bus.RX_D_VLD) w_next = ST_WR_STB;
      ST_WR_STB:  w_next = ST_IDLE;
      ST_RD_STB:  w_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (bus.RdData_Valid) w_next = ST_TX_SEND;
        else if (w_timeout)   w_next = ST_IDLE;
      end
      ST_TX_SEND: if (r_txvld) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; outputs never see inputs directly
  always_comb begin
    w_ld_addr   = bus.RX_D_VLD && ((r_state == ST_WR_ADDR) || (r_state == ST_RD_ADDR));
    w_ld_wrdata = bus.RX_D_VLD && (r_state == ST_WR_DATA);
    w_ld_txdata = (r_state == ST_RD_WAIT) && bus.RdData_Valid;
    w_wren      = w_ld_wrdata;
    w_rden      = bus.RX_D_VLD && (r_state == ST_RD_ADDR) && !w_hi_nz;
    w_txvld     = !bus.TX_BUSY &&
                  (w_ld_txdata || ((r_state == ST_TX_SEND) && !r_txvld));
    w_err       = 1'b0;
    unique case (r_state)
      ST_IDLE:                w_err = bus.RX_D_VLD && !w_is_wr && !w_is_rd;
      ST_WR_ADDR, ST_RD_ADDR: w_err = bus.RX_D_VLD && w_hi_nz;
      ST_WR_DATA:             w_err = 1'b0;
      default:                w_err = bus.RX_D_VLD || w_timeout;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wren   <= 1'b0;
      r_rden   <= 1'b0;
      r_txvld  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wrdata <= '0;
      r_txdata <= '0;
    end else begin
      r_wren  <= w_wren;
      r_rden  <= w_rden;
      r_txvld <= w_txvld;
      r_err   <= w_err;
      r_cnt   <= (r_state == ST_RD_WAIT) ? r_cnt + 3'd1 : 3'd0;
      if (w_ld_addr)   r_addr   <= bus.RX_P_DATA[ADD-1:0];
      if (w_ld_wrdata) r_wrdata <= bus.RX_P_DATA;
      if (w_ld_txdata) r_txdata <= bus.RdData;
    end
  end

  assign bus.WrEn      = r_wren;
  assign bus.RdEn      = r_rden;
  assign bus.Address   = r_addr;
  assign bus.WrData    = r_wrdata;
  assign bus.TX_P_DATA = r_txdata;
  assign bus.TX_D_VLD  = r_txvld;
  assign bus.CMD_ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_cmd_ctrl : directed frames against reg_cmd_ctrl with a 1-cycle
//                   register-file model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_reg_cmd_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_cmd_ctrl_if #(.DATA(8), .ADD(4)) bus ();

  reg_cmd_ctrl #(.DATA(8), .ADD(4)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file with reset contents 2:0x81 and 3:0x20
  logic [7:0] rf [16];
  logic       rf_hold = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      rf[2]            <= 8'h81;
      rf[3]            <= 8'h20;
      bus.RdData       <= 8'h00;
      bus.RdData_Valid <= 1'b0;
    end else begin
      bus.RdData_Valid <= bus.RdEn && !rf_hold;
      if (bus.RdEn) bus.RdData <= rf[bus.Address];
      if (bus.WrEn) rf[bus.Address] <= bus.WrData;
    end
  end

  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, both_cnt = 0;
  int wr_cyc = 0, rd_cyc = 0, tx_cyc = 0, err_cyc = 0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0, tx_data = '0;

  always @(negedge clk) begin
    if (bus.WrEn) begin
      wr_cnt <= wr_cnt + 1; wr_cyc <= cyc; wr_addr <= bus.Address; wr_data <= bus.WrData;
    end
    if (bus.RdEn) begin
      rd_cnt <= rd_cnt + 1; rd_cyc <= cyc; rd_addr <= bus.Address;
    end
    if (bus.TX_D_VLD) begin
      tx_cnt <= tx_cnt + 1; tx_cyc <= cyc; tx_data <= bus.TX_P_DATA;
    end
    if (bus.CMD_ERR) begin
      err_cnt <= err_cnt + 1; err_cyc <= cyc;
    end
    if (bus.WrEn && bus.RdEn) both_cnt <= both_cnt + 1;
  end

  int last_samp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte is sampled on the posedge between the two negedges
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge clk);
    bus.RX_D_VLD  = 1'b0;
    last_samp     = cyc;
  endtask

  int b_wr, b_rd, b_tx, b_err, s, k, bad;

  initial begin
    bus.RX_P_DATA = 8'h00;
    bus.RX_D_VLD  = 1'b0;
    bus.TX_BUSY   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_WrEn",      32'(bus.WrEn),      0);
    check("rst_RdEn",      32'(bus.RdEn),      0);
    check("rst_Address",   32'(bus.Address),   0);
    check("rst_WrData",    32'(bus.WrData),    0);
    check("rst_TX_P_DATA", 32'(bus.TX_P_DATA), 0);
    check("rst_TX_D_VLD",  32'(bus.TX_D_VLD),  0);
    check("rst_CMD_ERR",   32'(bus.CMD_ERR),   0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write AA 05 3C
    b_wr = wr_cnt; b_tx = tx_cnt;
    send(8'hAA); send(8'h05); send(8'h3C); s = last_samp;
    repeat (4) @(negedge clk);
    check("wr1_count", wr_cnt - b_wr, 1);
    check("wr1_cycle", wr_cyc, s);
    check("wr1_addr",  32'(wr_addr), 32'h5);
    check("wr1_data",  32'(wr_data), 32'h3C);
    check("wr1_no_tx", tx_cnt - b_tx, 0);

    // Read BB 02
    b_rd = rd_cnt; b_tx = tx_cnt;
    send(8'hBB); send(8'h02); s = last_samp;
    repeat (6) @(negedge clk);
    check("rd2_count",   rd_cnt - b_rd, 1);
    check("rd2_cycle",   rd_cyc, s);
    check("rd2_addr",    32'(rd_addr), 32'h2);
    check("rd2_tx_cnt",  tx_cnt - b_tx, 1);
    check("rd2_tx_cyc",  tx_cyc, s + 2);
    check("rd2_tx_data", 32'(tx_data), 32'h81);

    // Write C3 to register 7, then read it back while TX is busy
    b_wr = wr_cnt;
    send(8'hAA); send(8'h07); send(8'hC3);
    repeat (2) @(negedge clk);
    check("wr7_count", wr_cnt - b_wr, 1);
    b_tx = tx_cnt;
    bus.TX_BUSY = 1'b1;
    send(8'hBB); send(8'h07);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.TX_D_VLD !== 1'b0 || bus.TX_P_DATA !== 8'hC3) bad++;
    end
    check("busy_hold", bad, 0);
    @(negedge clk);
    bus.TX_BUSY = 1'b0;
    k = cyc;
    repeat (5) @(negedge clk);
    check("busy_tx_cnt",  tx_cnt - b_tx, 1);
    check("busy_tx_cyc",  tx_cyc, k + 1);
    check("busy_tx_data", 32'(tx_data), 32'hC3);
    check("busy_tx_keep", 32'(bus.TX_P_DATA), 32'hC3);

    // Unknown opcode in IDLE
    b_wr = wr_cnt; b_rd = rd_cnt; b_err = err_cnt;
    send(8'h55); s = last_samp;
    repeat (3) @(negedge clk);
    check("bad_op_err",  err_cnt - b_err, 1);
    check("bad_op_cyc",  err_cyc, s);
    check("bad_op_nowr", wr_cnt - b_wr, 0);
    check("bad_op_nord", rd_cnt - b_rd, 0);

    // Address with high bits set, then a clean write
    b_wr = wr_cnt; b_err = err_cnt;
    send(8'hAA); send(8'h1F); s = last_samp;
    repeat (3) @(negedge clk);
    check("bad_addr_err",  err_cnt - b_err, 1);
    check("bad_addr_cyc",  err_cyc, s);
    check("bad_addr_nowr", wr_cnt - b_wr, 0);
    send(8'hAA); send(8'h01); send(8'h02); s = last_samp;
    repeat (3) @(negedge clk);
    check("wr_after_err_cnt",  wr_cnt - b_wr, 1);
    check("wr_after_err_cyc",  wr_cyc, s);
    check("wr_after_err_addr", 32'(wr_addr), 32'h1);
    check("wr_after_err_data", 32'(wr_data), 32'h02);

    // Read with the qualifier withheld
    rf_hold = 1'b1;
    b_err = err_cnt; b_tx = tx_cnt; b_rd = rd_cnt;
    send(8'hBB); send(8'h04);
    repeat (8) @(negedge clk);
    check("tmo_rd_cnt",  rd_cnt - b_rd, 1);
    check("tmo_err_cnt", err_cnt - b_err, 1);
    check("tmo_err_cyc", err_cyc, rd_cyc + 4);
    check("tmo_no_tx",   tx_cnt - b_tx, 0);
    rf_hold = 1'b0;
    send(8'hBB); send(8'h03); s = last_samp;
    repeat (6) @(negedge clk);
    check("rd3_tx_cnt",  tx_cnt - b_tx, 1);
    check("rd3_tx_cyc",  tx_cyc, s + 2);
    check("rd3_tx_data", 32'(tx_data), 32'h20);

    // Reset between address and data bytes
    send(8'hAA); send(8'h09);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_Address",   32'(bus.Address),   0);
    check("mid_rst_WrData",    32'(bus.WrData),    0);
    check("mid_rst_TX_P_DATA", 32'(bus.TX_P_DATA), 0);
    check("mid_rst_strobes",   32'({bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.CMD_ERR}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    b_wr = wr_cnt; b_rd = rd_cnt; b_err = err_cnt;
    @(negedge clk);
    send(8'h10); s = last_samp;
    repeat (4) @(negedge clk);
    check("post_rst_err",  err_cnt - b_err, 1);
    check("post_rst_cyc",  err_cyc, s);
    check("post_rst_nowr", wr_cnt - b_wr, 0);
    check("post_rst_nord", rd_cnt - b_rd, 0);

    check("wr_rd_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
